// File: rtl/aes_invunit.sv
// Byte-serial GF(2^8) inverse for the S-box: a 32-bit word is inverted one byte per cycle
// through a composite-field GF((2^4)^2) datapath, with an optional register after the GF(2^4) inverse.
//   state | meaning
//   IDLE  | ready for a new word
//   RUN   | issuing bytes 0..3, then draining the pipeline
//   DONE  | result word valid, held until downstream accepts
module aes_invunit #(
  parameter int PIPE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST_STEP = 3'(3 + PIPE);

  // GF(2^2) modulo y^2+y+1
  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    gf2_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // GF((2^2)^2) modulo z^2+z+phi, phi = {10}
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, hl, lh, ll;
    hh = gf2_mul(a[3:2], b[3:2]);
    hl = gf2_mul(a[3:2], b[1:0]);
    lh = gf2_mul(a[1:0], b[3:2]);
    ll = gf2_mul(a[1:0], b[1:0]);
    gf4_mul = {hh ^ hl ^ lh, gf2_mul(hh, 2'b10) ^ ll};
  endfunction

  // a^14 = a^-1 for nonzero a, and maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    gf4_inv = gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] map_fwd(input logic [7:0] q);
    logic [7:0] m;
    m[7] = q[7] ^ q[5];
    m[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    m[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
    m[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
    m[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
    m[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    m[1] = q[6] ^ q[4] ^ q[1];
    m[0] = q[6] ^ q[1] ^ q[0];
    map_fwd = m;
  endfunction

  function automatic logic [7:0] map_inv(input logic [7:0] q);
    logic [7:0] m;
    m[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
    m[6] = q[6] ^ q[2];
    m[5] = q[6] ^ q[5] ^ q[1];
    m[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
    m[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    m[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
    m[1] = q[5] ^ q[4];
    m[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
    map_inv = m;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_step;
  logic [31:0] r_din;
  logic [31:0] r_res;
  logic        w_accept;
  logic        w_issue;
  logic [7:0]  w_byte;
  logic [7:0]  w_map;
  logic [3:0]  w_h, w_l, w_t, w_d;
  logic [3:0]  w_be_h, w_be_l, w_be_d;
  logic        w_be_vld;
  logic [1:0]  w_be_lane;
  logic [7:0]  w_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    busy_o   = 1'b0;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o  = ~rst_i;
        w_accept = valid_i;
        if (valid_i) w_next = RUN;
      end
      RUN: begin
        busy_o  = 1'b1;
        w_issue = ~r_step[2];
        if (r_step == LAST_STEP) w_next = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Front end: map to the composite field and invert the norm h^2*lambda + h*l + l^2
  assign w_byte = r_din[{r_step[1:0], 3'b000} +: 8];
  assign w_map  = map_fwd(w_byte);
  assign w_h    = w_map[7:4];
  assign w_l    = w_map[3:0];
  assign w_t    = gf4_mul(gf4_mul(w_h, w_h), 4'hC) ^ gf4_mul(w_h, w_l) ^ gf4_mul(w_l, w_l);
  assign w_d    = gf4_inv(w_t);

  if (PIPE == 1) begin : g_pipe
    logic [3:0] r_ph, r_pl, r_pd;
    logic       r_pv;
    logic [1:0] r_plane;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_ph    <= '0;
        r_pl    <= '0;
        r_pd    <= '0;
        r_pv    <= 1'b0;
        r_plane <= '0;
      end else begin
        r_ph    <= w_h;
        r_pl    <= w_l;
        r_pd    <= w_d;
        r_pv    <= w_issue;
        r_plane <= r_step[1:0];
      end
    end
    assign w_be_h    = r_ph;
    assign w_be_l    = r_pl;
    assign w_be_d    = r_pd;
    assign w_be_vld  = r_pv;
    assign w_be_lane = r_plane;
  end else begin : g_comb
    assign w_be_h    = w_h;
    assign w_be_l    = w_l;
    assign w_be_d    = w_d;
    assign w_be_vld  = w_issue;
    assign w_be_lane = r_step[1:0];
  end

  // Back end: (h*d) x + (h+l)*d, then map back to polynomial basis
  assign w_res = map_inv({gf4_mul(w_be_h, w_be_d), gf4_mul(w_be_h ^ w_be_l, w_be_d)});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_din  <= '0;
      r_step <= '0;
      r_res  <= '0;
    end else begin
      if (w_accept) begin
        r_din  <= data_i;
        r_step <= '0;
      end else if (r_state == RUN) begin
        r_step <= r_step + 3'd1;
      end
      if (w_be_vld) r_res[{w_be_lane, 3'b000} +: 8] <= w_res;
    end
  end

  assign data_o = r_res;

endmodule
